// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
//   i2c_tgt_state_t    : target protocol FSM states
//   I2C_ACK / I2C_NACK : SDA level in the acknowledge slot
//   I2C_BITS_PER_BYTE  : data bits per byte on the bus
//   addr_match()       : compares the {addr, rw} byte against a 7-bit address
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned I2C_BITS_PER_BYTE = 8;

  function automatic logic addr_match(input logic [7:0] addr_rw, input logic [6:0] target);
    return addr_rw[7:1] == target;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// I2C line conditioner: synchronizes SCL/SDA into the clk domain, optionally
// majority-filters them, and derives SCL edges and START/STOP conditions.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample filter).
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   scl_i, sda_i : raw bus pins
//   sda_o        : conditioned SDA level
//   scl_rise_o   : 1-cycle pulse on conditioned SCL rising edge
//   scl_fall_o   : 1-cycle pulse on conditioned SCL falling edge
//   start_det_o  : SDA fell while SCL stayed high
//   stop_det_o   : SDA rose while SCL stayed high
module i2c_line_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_sync;
  logic                   sda_sync;
  logic                   scl_c;
  logic                   sda_c;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Reset to the idle bus level so leaving reset does not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_sync = scl_sync_q[SYNC_STAGES-1];
  assign sda_sync = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q;
  logic [1:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync};
      sda_hist_q <= {sda_hist_q[0], sda_sync};
      scl_filt_q <= scl_c;
      sda_filt_q <= sda_c;
    end
  end

  // Follow the input only once the current and two previous samples agree.
  always_comb begin
    scl_c = scl_filt_q;
    sda_c = sda_filt_q;
    if (scl_sync == scl_hist_q[0] && scl_sync == scl_hist_q[1]) scl_c = scl_sync;
    if (sda_sync == sda_hist_q[0] && sda_sync == sda_hist_q[1]) sda_c = sda_sync;
  end
`else
  assign scl_c = scl_sync;
  assign sda_c = sda_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  assign sda_o      = sda_c;
  assign scl_rise_o = scl_c & ~scl_prev_q;
  assign scl_fall_o = ~scl_c & scl_prev_q;
  // SCL must be high in both samples, so an SDA change coinciding with an SCL
  // change is never taken as START/STOP.
  assign start_det_o = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det_o  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target. Receives write bytes (ACKing every one) and
// shifts read bytes out of tx_data. Never stretches SCL.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_cond).
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   I2C_SCL    : bus clock input
//   I2C_SDA    : bus data, driven low or released only
//   tx_data    : byte returned in the next read byte slot
//   tx_load    : pulse when tx_data is sampled into the shifter
//   rx_data    : last byte received in a write
//   rx_valid   : pulse when rx_data updates
//   addressed  : high from address ACK until STOP, repeated START or end of read
//   rw         : R/W bit of the current addressed transfer
//   stop_det   : pulse on any STOP on the bus
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       rw,
  output logic       stop_det
);

  localparam logic [3:0] LastBit = 4'(I2C_BITS_PER_BYTE - 1);
  localparam logic [3:0] AckSlot = 4'(I2C_BITS_PER_BYTE);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_seen;
  logic stop_seen;

  i2c_tgt_state_t state_q;
  logic [3:0]     bit_cnt_q;
  logic [6:0]     shift_q;
  logic           sda_oe_q;
  logic           addressed_q;
  logic           rw_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic           tx_load_q;
  logic           stop_det_q;

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (I2C_SCL),
    .sda_i      (I2C_SDA),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_seen),
    .stop_det_o (stop_seen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      stop_det_q <= 1'b0;
      if (start_seen) begin
        // Also covers repeated START: any partial byte is simply dropped.
        state_q     <= ADDR;
        bit_cnt_q   <= '0;
        addressed_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (stop_seen) begin
        state_q     <= IDLE;
        bit_cnt_q   <= '0;
        addressed_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        stop_det_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: ;

          ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LastBit) begin
                if (addr_match({shift_q, sda}, TARGET_ADDR)) rw_q <= sda;
                else                                         state_q <= IGNORE;
              end
            end else if (scl_fall && bit_cnt_q == AckSlot) begin
              sda_oe_q  <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= ADDR_ACK;
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              addressed_q <= 1'b1;
              bit_cnt_q   <= '0;
              if (!rw_q) begin
                sda_oe_q <= 1'b0;
                state_q  <= RX;
              end else begin
                shift_q   <= tx_data[6:0];
                tx_load_q <= 1'b1;
                sda_oe_q  <= ~tx_data[7];
                state_q   <= TX;
              end
            end
          end

          RX: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LastBit) begin
                rx_data_q  <= {shift_q, sda};
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall && bit_cnt_q == AckSlot) begin
              sda_oe_q  <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RX_ACK;
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= RX;
            end
          end

          TX: begin
            // bit_cnt counts bits the master has clocked in; bit7 is already
            // on the bus when TX is entered.
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == AckSlot) begin
                sda_oe_q <= 1'b0;
                state_q  <= TX_ACK;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[5:0], 1'b0};
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_NACK) begin
                addressed_q <= 1'b0;
                state_q     <= IGNORE;
              end
            end else if (scl_fall) begin
              // Only reachable after an ACK; a NACK has already left.
              shift_q   <= tx_data[6:0];
              tx_load_q <= 1'b1;
              sda_oe_q  <= ~tx_data[7];
              bit_cnt_q <= '0;
              state_q   <= TX;
            end
          end

          IGNORE: sda_oe_q <= 1'b0;

          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign I2C_SDA   = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_load   = tx_load_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged I2C initiator drives a
// table of transactions, then hand-written sequences cover multi-byte reads,
// repeated START mid-byte and reset during an ACK slot.
module tb_i2c_target;

  localparam int Q = 20;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       rw;
  logic       stop_det;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(
    .TARGET_ADDR(7'h42),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I2C_SCL  (scl),
    .I2C_SDA  (sda_bus),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addressed(addressed),
    .rw       (rw),
    .stop_det (stop_det)
  );

  int rxv_cnt = 0;
  int txl_cnt = 0;
  int stp_cnt = 0;

  always @(posedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (tx_load)  txl_cnt <= txl_cnt + 1;
    if (stop_det) stp_cnt <= stp_cnt + 1;
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_oe = 1'b0;
    scl = 1'b1;
    wait_clk(Q);
    m_sda_oe = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_rstart();
    m_sda_oe = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_oe = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda_oe = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_sda_oe = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_oe = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_oe = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q / 2);
    b = sda_bus;
    wait_clk(Q / 2);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  typedef struct {
    logic [7:0] addr;     // {addr, rw} byte sent by the master
    logic [7:0] data;     // write data, or tx_data offered for a read
    logic       exp_ack;  // target expected to ACK the address
    int         exp_rxv;  // rx_valid pulses expected
    int         exp_txl;  // tx_load pulses expected
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] rd;
    logic [7:0] rd2;
    int         rxv0;
    int         txl0;
    int         stp0;

    vecs[0] = '{addr: 8'h84, data: 8'h00, exp_ack: 1'b1, exp_rxv: 1, exp_txl: 0};
    vecs[1] = '{addr: 8'h85, data: 8'h3C, exp_ack: 1'b1, exp_rxv: 0, exp_txl: 1};
    vecs[2] = '{addr: 8'h90, data: 8'h5A, exp_ack: 1'b0, exp_rxv: 0, exp_txl: 0};
    vecs[3] = '{addr: 8'h84, data: 8'hA5, exp_ack: 1'b1, exp_rxv: 1, exp_txl: 0};
    vecs[4] = '{addr: 8'h85, data: 8'hFF, exp_ack: 1'b1, exp_rxv: 0, exp_txl: 1};
    vecs[5] = '{addr: 8'h00, data: 8'hC3, exp_ack: 1'b0, exp_rxv: 0, exp_txl: 0};
    vecs[6] = '{addr: 8'h85, data: 8'h80, exp_ack: 1'b1, exp_rxv: 0, exp_txl: 1};

    wait_clk(5);
    check("reset sda released", {31'd0, sda_bus}, 32'd1);
    check("reset outputs", {26'd0, addressed, rw, rx_valid, tx_load, stop_det, 1'b0}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    wait_clk(Q);

    for (int i = 0; i < 7; i++) begin
      rxv0 = rxv_cnt;
      txl0 = txl_cnt;
      stp0 = stp_cnt;
      tx_data = vecs[i].data;
      bus_start();
      write_byte(vecs[i].addr, ack);
      check($sformatf("v%0d addr ack", i), {31'd0, ~ack}, {31'd0, vecs[i].exp_ack});
      check($sformatf("v%0d addressed", i), {31'd0, addressed}, {31'd0, vecs[i].exp_ack});
      if (vecs[i].exp_ack)
        check($sformatf("v%0d rw", i), {31'd0, rw}, {31'd0, vecs[i].addr[0]});
      if (!vecs[i].addr[0]) begin
        write_byte(vecs[i].data, ack);
        check($sformatf("v%0d data ack", i), {31'd0, ~ack}, {31'd0, vecs[i].exp_ack});
        if (vecs[i].exp_ack)
          check($sformatf("v%0d rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].data});
        check($sformatf("v%0d addressed mid", i), {31'd0, addressed},
              {31'd0, vecs[i].exp_ack});
      end else begin
        read_byte(rd);
        write_bit(1'b1);
        check($sformatf("v%0d read byte", i), {24'd0, rd}, {24'd0, vecs[i].data});
        check($sformatf("v%0d addressed after nack", i), {31'd0, addressed}, 32'd0);
      end
      bus_stop();
      check($sformatf("v%0d rx_valid count", i), rxv_cnt - rxv0, vecs[i].exp_rxv);
      check($sformatf("v%0d tx_load count", i), txl_cnt - txl0, vecs[i].exp_txl);
      check($sformatf("v%0d stop_det count", i), stp_cnt - stp0, 32'd1);
      check($sformatf("v%0d addressed end", i), {31'd0, addressed}, 32'd0);
    end

    // Two-byte read: ACK the first byte, NACK the second.
    txl0 = txl_cnt;
    tx_data = 8'h11;
    bus_start();
    write_byte(8'h85, ack);
    check("rd2 addr ack", {31'd0, ack}, 32'd0);
    read_byte(rd);
    tx_data = 8'h22;
    write_bit(1'b0);
    check("rd2 addressed after ack", {31'd0, addressed}, 32'd1);
    read_byte(rd2);
    write_bit(1'b1);
    bus_stop();
    check("rd2 byte0", {24'd0, rd}, 32'h11);
    check("rd2 byte1", {24'd0, rd2}, 32'h22);
    check("rd2 tx_load count", txl_cnt - txl0, 32'd2);

    // Repeated START after four data bits of a write, then a read.
    rxv0 = rxv_cnt;
    txl0 = txl_cnt;
    tx_data = 8'h96;
    bus_start();
    write_byte(8'h84, ack);
    check("rs write ack", {31'd0, ack}, 32'd0);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    bus_rstart();
    check("rs addressed dropped", {31'd0, addressed}, 32'd0);
    write_byte(8'h85, ack);
    check("rs read ack", {31'd0, ack}, 32'd0);
    check("rs rw", {31'd0, rw}, 32'd1);
    check("rs addressed", {31'd0, addressed}, 32'd1);
    read_byte(rd);
    write_bit(1'b1);
    bus_stop();
    check("rs read byte", {24'd0, rd}, 32'h96);
    check("rs no partial rx_valid", rxv_cnt - rxv0, 32'd0);
    check("rs rx_data kept", {24'd0, rx_data}, 32'hA5);
    check("rs tx_load count", txl_cnt - txl0, 32'd1);

    // Reset while the target holds SDA low in the address ACK slot.
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 || i == 2 || i == 7);
    m_sda_oe = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q / 2);
    check("rst ack held low", {31'd0, sda_bus}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst sda released", {31'd0, sda_bus}, 32'd1);
    check("rst outputs", {27'd0, addressed, rw, rx_valid, tx_load, stop_det}, 32'd0);
    check("rst rx_data", {24'd0, rx_data}, 32'd0);
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(Q);

    // Target recovers for a normal write after the reset.
    rxv0 = rxv_cnt;
    bus_start();
    write_byte(8'h84, ack);
    check("post-rst addr ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, ack);
    check("post-rst data ack", {31'd0, ack}, 32'd0);
    bus_stop();
    check("post-rst rx_data", {24'd0, rx_data}, 32'h5A);
    check("post-rst rx_valid count", rxv_cnt - rxv0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
